// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: on a miss, fetches the 8-word block from main
// memory, writes each returned word into the data array, then writes the tag.
module cache_fill_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        memory_data_valid,
    output logic        fsm_busy,
    output logic        memory_request,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [15:0] fill_address,
    output logic        write_tag_array
);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] base_q, base_d;
    logic [3:0]  req_cnt_q, req_cnt_d;
    logic [3:0]  rcv_cnt_q, rcv_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            req_cnt_q <= '0;
            rcv_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            req_cnt_q <= req_cnt_d;
            rcv_cnt_q <= rcv_cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        req_cnt_d        = req_cnt_q;
        rcv_cnt_d        = rcv_cnt_q;
        fsm_busy         = 1'b0;
        memory_request   = 1'b0;
        memory_address   = 16'h0000;
        write_data_array = 1'b0;
        fill_address     = 16'h0000;
        write_tag_array  = 1'b0;

        case (state_q)
            IDLE: begin
                // Combinational stall so the pipeline freezes in the detecting cycle.
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    state_d   = FILL;
                    base_d    = miss_address[15:4];
                    req_cnt_d = 4'd0;
                    rcv_cnt_d = 4'd0;
                end
            end
            FILL: begin
                fsm_busy       = 1'b1;
                memory_address = {base_q, req_cnt_q[2:0], 1'b0};
                fill_address   = {base_q, rcv_cnt_q[2:0], 1'b0};
                if (req_cnt_q < 4'd8) begin
                    memory_request = 1'b1;
                    req_cnt_d      = req_cnt_q + 4'd1;
                end
                if (memory_data_valid && (rcv_cnt_q < 4'd8)) begin
                    write_data_array = 1'b1;
                    rcv_cnt_d        = rcv_cnt_q + 4'd1;
                    // Last word: tag goes in alongside the final data write.
                    if (rcv_cnt_q == 4'd7) begin
                        write_tag_array = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: scoreboard of expected request and
// fill addresses plus per-scenario cycle checks on busy/request/tag timing.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'h0000;
    logic        memory_data_valid = 1'b0;
    logic        fsm_busy;
    logic        memory_request;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] fill_address;
    logic        write_tag_array;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_wr    = 0;
    logic [15:0] exp_req[$];
    logic [15:0] exp_wr[$];

    always #5 clk = ~clk;

    cache_fill_fsm dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .memory_data_valid(memory_data_valid),
        .fsm_busy         (fsm_busy),
        .memory_request   (memory_request),
        .memory_address   (memory_address),
        .write_data_array (write_data_array),
        .fill_address     (fill_address),
        .write_tag_array  (write_tag_array)
    );

    task automatic push_reqs(input logic [15:0] a, input int n);
        for (int i = 0; i < n; i++) exp_req.push_back({a[15:4], 3'(i), 1'b0});
    endtask

    task automatic push_wrs(input logic [15:0] a, input int n);
        for (int i = 0; i < n; i++) exp_wr.push_back({a[15:4], 3'(i), 1'b0});
    endtask

    // One clock cycle: drive inputs after the falling edge, sample outputs 1ns later
    // and retire any request/write against the scoreboard.
    task automatic step(input logic m, input logic [15:0] a, input logic v, input logic r);
        logic [15:0] e;
        @(negedge clk);
        rst = r;
        miss_detected = m;
        miss_address = a;
        memory_data_valid = v;
        #1;
        if (memory_request) begin
            n_tests++;
            if (exp_req.size() == 0) begin
                n_fail++;
                $display("FAIL req_unexpected: got request addr %h, expected no request", memory_address);
            end else begin
                e = exp_req.pop_front();
                if (memory_address !== e) begin
                    n_fail++;
                    $display("FAIL req_addr: got %h, expected %h", memory_address, e);
                end
            end
        end
        if (write_data_array) begin
            n_wr++;
            n_tests++;
            if (exp_wr.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: got write addr %h, expected no write", fill_address);
            end else begin
                e = exp_wr.pop_front();
                if (fill_address !== e) begin
                    n_fail++;
                    $display("FAIL fill_addr: got %h, expected %h", fill_address, e);
                end
            end
        end
    endtask

    task automatic test_reset;
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        n_tests++;
        if ({fsm_busy, memory_request, write_data_array, write_tag_array} !== 4'b0000 ||
            memory_address !== 16'h0000 || fill_address !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b req=%b wr=%b tag=%b maddr=%h faddr=%h, expected all 0",
                     fsm_busy, memory_request, write_data_array, write_tag_array, memory_address, fill_address);
        end
        step(1'b1, 16'h1234, 1'b0, 1'b1);
        n_tests++;
        if (fsm_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy_follows_miss: got %b, expected 1", fsm_busy);
        end
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        n_tests++;
        if (write_data_array !== 1'b0 || fsm_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_stale_valid: got wr=%b busy=%b, expected 0 0", write_data_array, fsm_busy);
        end
    endtask

    task automatic test_basic_fill;
        n_wr = 0;
        push_reqs(16'h1236, 8);
        push_wrs(16'h1236, 8);
        step(1'b1, 16'h1236, 1'b0, 1'b0);
        n_tests++;
        if (fsm_busy !== 1'b1 || memory_request !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_c0: got busy=%b req=%b, expected 1 0", fsm_busy, memory_request);
        end
        for (int k = 1; k <= 13; k++) begin
            step(1'b0, 16'h0000, (k >= 5 && k <= 12), 1'b0);
            n_tests++;
            if (fsm_busy !== (k <= 12) || write_tag_array !== (k == 12) ||
                memory_request !== (k >= 1 && k <= 8)) begin
                n_fail++;
                $display("FAIL basic_timing c%0d: got busy=%b tag=%b req=%b, expected %b %b %b", k,
                         fsm_busy, write_tag_array, memory_request, (k <= 12), (k == 12), (k <= 8));
            end
        end
        n_tests++;
        if (exp_req.size() != 0 || exp_wr.size() != 0 || n_wr != 8) begin
            n_fail++;
            $display("FAIL basic_drain: got req_left=%0d wr_left=%0d writes=%0d, expected 0 0 8",
                     exp_req.size(), exp_wr.size(), n_wr);
        end
    endtask

    task automatic test_irregular_ignored;
        logic [31:0] sched;
        sched = 32'h0011_B1A0;  // valids in cycles 5,7,8,12,13,15,16,20
        n_wr = 0;
        push_reqs(16'h5678, 8);
        push_wrs(16'h5678, 8);
        step(1'b1, 16'h5678, 1'b0, 1'b0);
        for (int k = 1; k <= 21; k++) begin
            step((k == 3), (k == 3) ? 16'h4000 : 16'h0000, sched[k] || (k == 21), 1'b0);
            n_tests++;
            if (fsm_busy !== (k <= 20) || write_tag_array !== (k == 20) ||
                memory_request !== (k <= 8)) begin
                n_fail++;
                $display("FAIL irregular_timing c%0d: got busy=%b tag=%b req=%b, expected %b %b %b", k,
                         fsm_busy, write_tag_array, memory_request, (k <= 20), (k == 20), (k <= 8));
            end
        end
        n_tests++;
        if (write_data_array !== 1'b0) begin
            n_fail++;
            $display("FAIL extra_valid_write: got %b, expected 0", write_data_array);
        end
        n_tests++;
        if (exp_req.size() != 0 || exp_wr.size() != 0 || n_wr != 8) begin
            n_fail++;
            $display("FAIL irregular_drain: got req_left=%0d wr_left=%0d writes=%0d, expected 0 0 8",
                     exp_req.size(), exp_wr.size(), n_wr);
        end
    endtask

    task automatic test_back_to_back;
        n_wr = 0;
        for (int k = 0; k <= 26; k++) begin
            if (k == 0) begin
                push_reqs(16'h00F0, 8);
                push_wrs(16'h00F0, 8);
            end
            if (k == 13) begin
                push_reqs(16'hFFFE, 8);
                push_wrs(16'hFFFE, 8);
            end
            step((k <= 25), (k <= 12) ? 16'h00F0 : 16'hFFFE,
                 (k >= 5 && k <= 12) || (k >= 18 && k <= 25), 1'b0);
            n_tests++;
            if (fsm_busy !== (k <= 25) || write_tag_array !== (k == 12 || k == 25) ||
                memory_request !== ((k >= 1 && k <= 8) || (k >= 14 && k <= 21))) begin
                n_fail++;
                $display("FAIL b2b_timing c%0d: got busy=%b tag=%b req=%b", k,
                         fsm_busy, write_tag_array, memory_request);
            end
        end
        n_tests++;
        if (exp_req.size() != 0 || exp_wr.size() != 0 || n_wr != 16) begin
            n_fail++;
            $display("FAIL b2b_drain: got req_left=%0d wr_left=%0d writes=%0d, expected 0 0 16",
                     exp_req.size(), exp_wr.size(), n_wr);
        end
    endtask

    task automatic test_reset_mid;
        n_wr = 0;
        push_reqs(16'h3450, 6);
        push_wrs(16'h3450, 2);
        step(1'b1, 16'h3450, 1'b0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 16'h0000, (k >= 5), (k == 6));
            if (k == 6) begin
                n_tests++;
                if (exp_req.size() != 0 || exp_wr.size() != 0) begin
                    n_fail++;
                    $display("FAIL rst_mid_pre: got req_left=%0d wr_left=%0d, expected 0 0",
                             exp_req.size(), exp_wr.size());
                end
            end
            if (k >= 7) begin
                n_tests++;
                if ({fsm_busy, memory_request, write_data_array, write_tag_array} !== 4'b0000 ||
                    memory_address !== 16'h0000 || fill_address !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL rst_mid_idle c%0d: got busy=%b req=%b wr=%b tag=%b, expected all 0", k,
                             fsm_busy, memory_request, write_data_array, write_tag_array);
                end
            end
        end
        push_reqs(16'h2000, 8);
        push_wrs(16'h2000, 8);
        step(1'b1, 16'h2000, 1'b0, 1'b0);
        for (int k = 14; k <= 26; k++) begin
            step(1'b0, 16'h0000, (k >= 18 && k <= 25), 1'b0);
            n_tests++;
            if (fsm_busy !== (k <= 25) || write_tag_array !== (k == 25)) begin
                n_fail++;
                $display("FAIL rst_refill c%0d: got busy=%b tag=%b, expected %b %b", k,
                         fsm_busy, write_tag_array, (k <= 25), (k == 25));
            end
        end
        n_tests++;
        if (exp_req.size() != 0 || exp_wr.size() != 0 || n_wr != 10) begin
            n_fail++;
            $display("FAIL rst_refill_drain: got req_left=%0d wr_left=%0d writes=%0d, expected 0 0 10",
                     exp_req.size(), exp_wr.size(), n_wr);
        end
    endtask

    initial begin
        test_reset;
        test_basic_fill;
        test_irregular_ignored;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
